// File: rtl/pipe_pkg.sv
// Shared definitions for the two-entry skid pipeline stage.
// Holds the occupancy encoding, default widths and control-bit field offsets.
// Also provides the saturating increment used by the stall counter.
package pipe_pkg;

  // Occupancy encoding; the numeric value is exported directly as occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Default widths.
  localparam int CTRL_W_DEF  = 10;
  localparam int DATA_W_DEF  = 16;
  localparam int REGID_W_DEF = 3;

  // Bit offsets of the control fields inside the ctrl bundle.
  // Bits above CTRL_ZERO are spare and are carried through untouched.
  localparam int CTRL_WSPEC    = 0;
  localparam int CTRL_MEM2REG  = 1;
  localparam int CTRL_REGWRITE = 2;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_BRANCH   = 5;
  localparam int CTRL_ZERO     = 6;

  // Stall counter width and ceiling.
  localparam int          STALL_W   = 16;
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == STALL_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// Payload register with load enable and synchronous clear.
// Latency: 1 cycle from ld_i to q_o.
// No flow control of its own; the owner decides when to load.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Clear has priority over load; otherwise hold.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      q_q <= '0;
    end else if (ld_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline register (MAIN + SKID) between pipeline stages, with flush.
// Latency: 1 cycle from accept to out_valid; sustains one instruction per cycle.
// in_ready is a registered (state != FULL); no combinational path from out_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REGID_W = REGID_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_pc,
  input  logic [DATA_W-1:0]  in_alu,
  input  logic [DATA_W-1:0]  in_wdata,
  input  logic [REGID_W-1:0] in_regid,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_pc,
  output logic [DATA_W-1:0]  out_alu,
  output logic [DATA_W-1:0]  out_wdata,
  output logic [REGID_W-1:0] out_regid,
  output logic [1:0]         occupancy,
  output logic [15:0]        stall_cycles
);

  localparam int PAY_W = CTRL_W + 3 * DATA_W + REGID_W;

  state_e              state_q, state_d;
  logic                in_rdy_q;
  logic [STALL_W-1:0]  stall_q, stall_d;

  logic                in_fire, out_fire;
  logic                main_ld, skid_ld, main_from_skid;
  logic [PAY_W-1:0]    pay_in, main_d, main_q, skid_q;

  assign pay_in   = {in_ctrl, in_pc, in_alu, in_wdata, in_regid};
  assign in_fire  = in_valid & in_rdy_q;
  assign out_fire = out_valid & out_ready;

  // State register, registered in_ready and saturating stall counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_EMPTY;
      in_rdy_q <= 1'b1;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      in_rdy_q <= (state_d != ST_FULL);
      stall_q  <= stall_d;
    end
  end

  // Next occupancy; flush squashes everything, including this cycle's input.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire)      state_d = ST_FULL;
          else if (!in_fire && out_fire) state_d = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Slot load strobes and the MAIN input select.
  always_comb begin
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_EMPTY: main_ld = in_fire;
        ST_ONE: begin
          main_ld = in_fire & out_fire;
          skid_ld = in_fire & ~out_fire;
        end
        ST_FULL: begin
          main_ld        = out_fire;
          main_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stall counter counts every offered-but-refused cycle, flush or not.
  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_rdy_q) begin
      stall_d = sat_inc(stall_q);
    end
  end

  assign main_d = main_from_skid ? skid_q : pay_in;

  pipe_slot #(.W(PAY_W)) u_main (
    .clk_i (CLK),
    .clr_i (RST),
    .ld_i  (main_ld),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  pipe_slot #(.W(PAY_W)) u_skid (
    .clk_i (CLK),
    .clr_i (RST),
    .ld_i  (skid_ld),
    .d_i   (pay_in),
    .q_o   (skid_q)
  );

  // Outputs; ctrl is forced to zero on bubbles so downstream sees a NOP.
  always_comb begin
    in_ready     = in_rdy_q;
    out_valid    = (state_q != ST_EMPTY);
    occupancy    = state_q;
    stall_cycles = stall_q;
    {out_ctrl, out_pc, out_alu, out_wdata, out_regid} = main_q;
    if (!out_valid) begin
      out_ctrl = '0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, back-pressure, flush,
// reset mid-operation and stall-counter saturation.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_pipe_stage_skid;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid, in_ready;
  logic [9:0]  in_ctrl;
  logic [15:0] in_pc, in_alu, in_wdata;
  logic [2:0]  in_regid;
  logic        flush;
  logic        out_valid, out_ready;
  logic [9:0]  out_ctrl;
  logic [15:0] out_pc, out_alu, out_wdata;
  logic [2:0]  out_regid;
  logic [1:0]  occupancy;
  logic [15:0] stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  pipe_stage_skid dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_pc        (in_pc),
    .in_alu       (in_alu),
    .in_wdata     (in_wdata),
    .in_regid     (in_regid),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_pc       (out_pc),
    .out_alu      (out_alu),
    .out_wdata    (out_wdata),
    .out_regid    (out_regid),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present one instruction; payload fields derive from the alu value.
  task automatic offer(input logic [15:0] alu);
    in_valid = 1'b1;
    in_alu   = alu;
    in_pc    = alu + 16'h1000;
    in_wdata = ~alu;
    in_ctrl  = 10'h040 | {2'b00, alu[7:0]} | 10'h004;
    in_regid = alu[2:0];
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_pc = '0; in_alu = '0;
    in_wdata = '0; in_regid = '0; flush = 1'b0; out_ready = 1'b0;

    // ---- reset ----
    step(); step();
    RST = 1'b0;
    step();
    check_vec("rst_in_ready", in_ready, 1);
    check_vec("rst_out_valid", out_valid, 0);
    check_vec("rst_out_ctrl", out_ctrl, 0);
    check_vec("rst_occupancy", occupancy, 0);
    check_vec("rst_stall", stall_cycles, 0);

    // ---- streaming: one per cycle, one cycle latency ----
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check_vec("stream_in_ready", in_ready, 1);
      offer(16'(i));
      step();
      check_vec("stream_out_valid", out_valid, 1);
      check_vec("stream_out_alu", out_alu, i);
      check_vec("stream_occupancy", occupancy, 1);
    end
    check_vec("stream_out_pc", out_pc, 16'h1008);
    check_vec("stream_out_wdata", out_wdata, 16'hFFF7);
    check_vec("stream_out_ctrl", out_ctrl, 10'h04C);
    check_vec("stream_out_regid", out_regid, 0);
    in_valid = 1'b0;
    step();
    check_vec("drain_occupancy", occupancy, 0);
    check_vec("drain_out_ctrl", out_ctrl, 0);
    check_vec("stream_stall", stall_cycles, 0);

    // ---- back-pressure ----
    out_ready = 1'b0;
    offer(16'h00AA);
    step();
    check_vec("bp_a_occ", occupancy, 1);
    check_vec("bp_a_alu", out_alu, 16'h00AA);
    offer(16'h00BB);
    step();
    check_vec("bp_b_occ", occupancy, 2);
    check_vec("bp_b_in_ready", in_ready, 0);
    check_vec("bp_b_head", out_alu, 16'h00AA);
    offer(16'h00CC);
    step();
    check_vec("bp_c_stall1", stall_cycles, 1);
    check_vec("bp_c_occ", occupancy, 2);
    check_vec("bp_c_head", out_alu, 16'h00AA);
    step();
    check_vec("bp_c_stall2", stall_cycles, 2);
    out_ready = 1'b1;
    step();
    check_vec("bp_rel_head_b", out_alu, 16'h00BB);
    check_vec("bp_rel_occ", occupancy, 1);
    check_vec("bp_rel_in_ready", in_ready, 1);
    check_vec("bp_rel_stall", stall_cycles, 3);
    step();
    check_vec("bp_head_c", out_alu, 16'h00CC);
    check_vec("bp_c_occ1", occupancy, 1);
    in_valid = 1'b0;
    step();
    check_vec("bp_empty", occupancy, 0);
    check_vec("bp_stall_hold", stall_cycles, 3);

    // ---- flush while FULL with an input offered ----
    out_ready = 1'b0;
    offer(16'h00D1); step();
    offer(16'h00E2); step();
    check_vec("fl_full", occupancy, 2);
    offer(16'h00FF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_vec("fl_occ", occupancy, 0);
    check_vec("fl_out_valid", out_valid, 0);
    check_vec("fl_out_ctrl", out_ctrl, 0);
    check_vec("fl_in_ready", in_ready, 1);
    check_vec("fl_stall", stall_cycles, 4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check_vec("fl_no_ghost", out_valid, 0);
    offer(16'h0077);
    step();
    check_vec("fl_next_alu", out_alu, 16'h0077);
    in_valid = 1'b0;
    step();

    // ---- reset mid-operation ----
    out_ready = 1'b0;
    offer(16'h0031); step();
    offer(16'h0032); step();
    check_vec("rm_full", occupancy, 2);
    offer(16'h0033);
    out_ready = 1'b1;
    RST = 1'b1;
    step();
    RST = 1'b0;
    in_valid = 1'b0;
    check_vec("rm_occ", occupancy, 0);
    check_vec("rm_out_valid", out_valid, 0);
    check_vec("rm_in_ready", in_ready, 1);
    check_vec("rm_stall", stall_cycles, 0);
    check_vec("rm_payload", {out_ctrl, out_pc[5:0], out_alu, out_regid}, 0);
    check_vec("rm_wdata_pc", {out_wdata, out_pc}, 0);

    // ---- stall counter saturation ----
    out_ready = 1'b0;
    offer(16'h0041); step();
    offer(16'h0042); step();
    offer(16'h0043);
    for (int i = 0; i < 70000; i++) begin
      @(posedge CLK);
    end
    #1;
    check_vec("sat_value", stall_cycles, 16'hFFFF);
    check_vec("sat_head", out_alu, 16'h0041);
    step(); step(); step();
    check_vec("sat_hold", stall_cycles, 16'hFFFF);
    in_valid = 1'b0;
    step();
    check_vec("sat_idle_hold", stall_cycles, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
